vector_lsu: RTL and testbench

- Initiator-side vector load/store unit for the 8-lane strided data memory (20-bit address, 8 lanes x 8 bits, lane k at Addr + 8*k, combinational read, write on negedge CLK).
- Accepts burst requests from the vector pipeline, generates per-beat memory addresses, returns load vectors through a valid/ready stream, and consumes store vectors from a valid/ready stream.
- Performs bounds checking and owns the memory WE/Addr/WD drive.

---
 rtl/vlsu_pkg.sv | 33 +++
 rtl/vlsu_beat_counter.sv | 44 ++++
 rtl/vector_lsu.sv | 114 +++++++++++
 tb/tb_vector_lsu.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vlsu_pkg.sv
// Shared types and constants for the vector load/store unit.
package vlsu_pkg;

   localparam int ADDR_W      = 20;
   localparam int CNT_W       = 5;
   localparam int ADDR_STEP   = 1;
   localparam int LANES       = 8;
   localparam int ELEM_W      = 8;
   localparam int LANE_STRIDE = 8;
   localparam int MEM_DEPTH   = 36864;

   typedef logic [LANES-1:0][ELEM_W-1:0] vec_t;

   typedef enum logic [2:0] {
      IDLE,
      LD_ISSUE,
      LD_OUT,
      ST_WAIT,
      ST_WRITE
   } vlsu_state_e;

   // Highest byte address a burst touches, one bit wider than the bus so
   // requests near the top of the address space cannot wrap into range.
   function automatic logic [ADDR_W:0] burst_last_addr(input logic [ADDR_W-1:0] base,
                                                      input logic [CNT_W-1:0]  count);
      logic [ADDR_W:0] beats_m1;
      beats_m1 = {{(ADDR_W+1-CNT_W){1'b0}}, count} - (ADDR_W+1)'(1);
      return {1'b0, base}
             + beats_m1 * (ADDR_W+1)'(ADDR_STEP)
             + (ADDR_W+1)'((LANES-1)*LANE_STRIDE);
   endfunction

endpackage

// File: rtl/vlsu_beat_counter.sv
// Burst address/beat tracker plus range check for the request on the bus.
module vlsu_beat_counter
   import vlsu_pkg::*;
(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              load,
   input  logic              step,
   input  logic [ADDR_W-1:0] load_addr,
   input  logic [CNT_W-1:0]  load_count,
   output logic [ADDR_W-1:0] addr,
   output logic              is_last,
   output logic              range_ok
);

   logic [CNT_W-1:0] beat;
   logic [CNT_W-1:0] last_beat;
   logic [ADDR_W:0]  req_last;

   // Accept only non-empty bursts whose top lane of the final beat is in memory.
   always_comb begin
      req_last = burst_last_addr(load_addr, load_count);
      range_ok = (load_count != '0) && (req_last < (ADDR_W+1)'(MEM_DEPTH));
   end

   // Current beat address and index; load starts a burst, step advances it.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         addr      <= '0;
         beat      <= '0;
         last_beat <= '0;
      end else if (load) begin
         addr      <= load_addr;
         beat      <= '0;
         last_beat <= load_count - CNT_W'(1);
      end else if (step) begin
         addr      <= addr + ADDR_W'(ADDR_STEP);
         beat      <= beat + CNT_W'(1);
      end
   end

   assign is_last = (beat == last_beat);

endmodule

// File: rtl/vector_lsu.sv
// Vector load/store unit: turns burst requests into per-beat accesses of the
// 8-lane strided data memory, streaming loads out and stores in.
module vector_lsu
   import vlsu_pkg::*;
(
   input  logic              CLK,
   input  logic              RST_n,
   input  logic              req_valid,
   output logic              req_ready,
   input  logic              req_store,
   input  logic [ADDR_W-1:0] req_addr,
   input  logic [CNT_W-1:0]  req_count,
   input  logic              wd_valid,
   output logic              wd_ready,
   input  vec_t              wd_data,
   output logic              rd_valid,
   input  logic              rd_ready,
   output vec_t              rd_data,
   output logic              rd_last,
   output logic              done,
   output logic              err,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_we,
   output vec_t              mem_wd,
   input  vec_t              mem_rd
);

   vlsu_state_e state;
   logic        range_ok;
   logic        is_last;
   logic        ctr_load;
   logic        ctr_step;

   assign req_ready = (state == IDLE);
   assign wd_ready  = (state == ST_WAIT);

   // The counter register doubles as the memory address, so it only moves on
   // posedge and always at the same edge that drops mem_we.
   assign ctr_load = req_ready && req_valid && range_ok;
   assign ctr_step = ((state == LD_OUT) && rd_ready && !is_last) ||
                     ((state == ST_WRITE) && !is_last);

   vlsu_beat_counter u_ctr (
      .clk        (CLK),
      .rst_n      (RST_n),
      .load       (ctr_load),
      .step       (ctr_step),
      .load_addr  (req_addr),
      .load_count (req_count),
      .addr       (mem_addr),
      .is_last    (is_last),
      .range_ok   (range_ok)
   );

   // Burst sequencer with registered stream, status and memory-write outputs.
   always_ff @(posedge CLK or negedge RST_n) begin
      if (!RST_n) begin
         state    <= IDLE;
         mem_we   <= 1'b0;
         mem_wd   <= '0;
         rd_valid <= 1'b0;
         rd_data  <= '0;
         rd_last  <= 1'b0;
         done     <= 1'b0;
         err      <= 1'b0;
      end else begin
         done <= 1'b0;
         err  <= 1'b0;
         case (state)
            IDLE: begin
               if (req_valid) begin
                  if (range_ok) state <= req_store ? ST_WAIT : LD_ISSUE;
                  else          err   <= 1'b1;
               end
            end
            LD_ISSUE: begin
               rd_data  <= mem_rd;
               rd_valid <= 1'b1;
               rd_last  <= is_last;
               state    <= LD_OUT;
            end
            LD_OUT: begin
               if (rd_ready) begin
                  rd_valid <= 1'b0;
                  if (is_last) begin
                     done  <= 1'b1;
                     state <= IDLE;
                  end else begin
                     state <= LD_ISSUE;
                  end
               end
            end
            ST_WAIT: begin
               if (wd_valid) begin
                  mem_wd <= wd_data;
                  mem_we <= 1'b1;
                  state  <= ST_WRITE;
               end
            end
            ST_WRITE: begin
               mem_we <= 1'b0;
               if (is_last) begin
                  done  <= 1'b1;
                  state <= IDLE;
               end else begin
                  state <= ST_WAIT;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_vector_lsu.sv
// Bench for vector_lsu: strided byte memory model, directed sequences,
// a request table and randomized bursts against a reference memory image.
module tb_vector_lsu;

   localparam int DEPTH = 36864;

   logic        CLK;
   logic        RST_n;
   logic        req_valid, req_ready, req_store;
   logic [19:0] req_addr;
   logic [4:0]  req_count;
   logic        wd_valid, wd_ready;
   logic [63:0] wd_data;
   logic        rd_valid, rd_ready, rd_last;
   logic [63:0] rd_data;
   logic        done, err;
   logic [19:0] mem_addr;
   logic        mem_we;
   logic [63:0] mem_wd, mem_rd;

   logic [7:0]  tbmem  [0:DEPTH-1];
   logic [7:0]  refmem [0:DEPTH-1];

   int n_checks = 0;
   int n_fail   = 0;
   int rd_hs    = 0;
   int done_cnt = 0;
   int we_cnt   = 0;
   int clash    = 0;

   typedef struct {
      logic        st;
      logic [19:0] addr;
      logic [4:0]  cnt;
      logic        acc;
   } vec_s;

   vec_s tbl [10];

   vector_lsu dut (
      .CLK       (CLK),
      .RST_n     (RST_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_store (req_store),
      .req_addr  (req_addr),
      .req_count (req_count),
      .wd_valid  (wd_valid),
      .wd_ready  (wd_ready),
      .wd_data   (wd_data),
      .rd_valid  (rd_valid),
      .rd_ready  (rd_ready),
      .rd_data   (rd_data),
      .rd_last   (rd_last),
      .done      (done),
      .err       (err),
      .mem_addr  (mem_addr),
      .mem_we    (mem_we),
      .mem_wd    (mem_wd),
      .mem_rd    (mem_rd)
   );

   initial begin
      CLK = 1'b0;
      forever #5 CLK = ~CLK;
   end

   // Combinational strided read: lane k comes from Addr + 8k.
   always_comb begin
      mem_rd = '0;
      for (int k = 0; k < 8; k++)
         if (int'(mem_addr) + 8*k < DEPTH) mem_rd[8*k +: 8] = tbmem[int'(mem_addr) + 8*k];
   end

   // Memory contents start as mem[i] = i and commit writes on negedge.
   initial begin
      for (int i = 0; i < DEPTH; i++) tbmem[i] = i[7:0];
      forever begin
         @(negedge CLK);
         if (mem_we === 1'b1)
            for (int k = 0; k < 8; k++)
               if (int'(mem_addr) + 8*k < DEPTH) tbmem[int'(mem_addr) + 8*k] = mem_wd[8*k +: 8];
      end
   end

   always @(posedge CLK) begin
      if (rd_valid && rd_ready) rd_hs <= rd_hs + 1;
      if (done) done_cnt <= done_cnt + 1;
   end

   always @(negedge CLK) begin
      if (mem_we) we_cnt <= we_cnt + 1;
      if (done && err) clash <= clash + 1;
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic tick();
      @(posedge CLK);
      #1;
   endtask

   function automatic logic [63:0] ref_vec(input int a);
      logic [63:0] v;
      v = '0;
      for (int k = 0; k < 8; k++)
         if (a + 8*k < DEPTH) v[8*k +: 8] = refmem[a + 8*k];
      return v;
   endfunction

   function automatic void ref_write(input int a, input logic [63:0] v);
      for (int k = 0; k < 8; k++)
         if (a + 8*k < DEPTH) refmem[a + 8*k] = v[8*k +: 8];
   endfunction

   function automatic logic model_accept(input int a, input int c);
      return (c != 0) && (a + (c - 1) + 56 < DEPTH);
   endfunction

   // One complete request. Fixed mode stalls/gaps only beat sbeat for slen
   // cycles and stores the pattern 0xA0 + 16*beat + lane.
   task automatic run_burst(input logic st, input logic [19:0] a, input logic [4:0] c,
                            input logic exp_acc, input logic rnd, input int sbeat, input int slen);
      int we0, hs0, dn0, n, gap;
      logic [63:0] exp, v;
      logic lastb;
      we0 = we_cnt; hs0 = rd_hs; dn0 = done_cnt;
      check("req_ready_idle", req_ready, 1'b1);
      req_valid = 1'b1; req_store = st; req_addr = a; req_count = c;
      tick();
      req_valid = 1'b0;
      check("err_pulse", err, !exp_acc);
      if (!exp_acc) begin
         check("reject_we", mem_we, 1'b0);
         check("reject_ready", req_ready, 1'b1);
         tick();
         check("err_single", err, 1'b0);
         return;
      end
      for (int j = 0; j < int'(c); j++) begin
         lastb = (j == int'(c) - 1);
         gap = rnd ? int'($urandom_range(0, 2)) : ((j == sbeat) ? slen : 0);
         if (!st) begin
            n = 0;
            while (!rd_valid && n < 8) begin tick(); n++; end
            if (!rd_valid) begin check("rd_valid_timeout", 1'b0, 1'b1); return; end
            exp = ref_vec(int'(a) + j);
            for (int s = 0; s < gap; s++) begin
               tick();
               check("rd_stall_valid", rd_valid, 1'b1);
               check("rd_stall_data", rd_data, exp);
            end
            check("rd_data", rd_data, exp);
            check("rd_last", rd_last, lastb);
            rd_ready = 1'b1;
            tick();
            rd_ready = 1'b0;
            check("rd_valid_drop", rd_valid, 1'b0);
            check("ld_done", done, lastb);
         end else begin
            check("wd_ready_wait", wd_ready, 1'b1);
            for (int s = 0; s < gap; s++) begin
               tick();
               check("st_gap_we", mem_we, 1'b0);
            end
            if (rnd) v = {$urandom, $urandom};
            else for (int k = 0; k < 8; k++) v[8*k +: 8] = 8'hA0 + 8'(16*j + k);
            wd_valid = 1'b1; wd_data = v;
            tick();
            wd_valid = 1'b0;
            check("st_we_high", mem_we, 1'b1);
            check("st_wd", mem_wd, v);
            check("st_addr", mem_addr, a + 20'(j));
            check("st_wd_ready_low", wd_ready, 1'b0);
            tick();
            ref_write(int'(a) + j, v);
            check("st_we_low", mem_we, 1'b0);
            check("st_done", done, lastb);
         end
      end
      tick();
      check("done_single", done, 1'b0);
      check("done_count", done_cnt - dn0, 1);
      check("we_cycles", we_cnt - we0, st ? int'(c) : 0);
      if (!st) check("rd_handshakes", rd_hs - hs0, int'(c));
   endtask

   initial begin
      logic [63:0] v0, v1;
      int we0, hs0, dn0, bad;

      RST_n = 1'b0; req_valid = 1'b0; req_store = 1'b0; req_addr = '0; req_count = '0;
      wd_valid = 1'b0; wd_data = '0; rd_ready = 1'b0;
      for (int i = 0; i < DEPTH; i++) refmem[i] = i[7:0];

      tbl[0] = '{1'b0, 20'h00010, 5'd1,  1'b1};
      tbl[1] = '{1'b0, 20'd36807, 5'd1,  1'b1};
      tbl[2] = '{1'b0, 20'd36807, 5'd2,  1'b0};
      tbl[3] = '{1'b0, 20'h00040, 5'd0,  1'b0};
      tbl[4] = '{1'b1, 20'd36807, 5'd1,  1'b1};
      tbl[5] = '{1'b0, 20'd36808, 5'd1,  1'b0};
      tbl[6] = '{1'b1, 20'hFFFF0, 5'd16, 1'b0};
      tbl[7] = '{1'b0, 20'h00000, 5'd16, 1'b1};
      tbl[8] = '{1'b1, 20'd36792, 5'd16, 1'b1};
      tbl[9] = '{1'b1, 20'd36793, 5'd16, 1'b0};

      repeat (3) @(posedge CLK);
      #1;
      check("rst_req_ready", req_ready, 1'b1);
      check("rst_wd_ready", wd_ready, 1'b0);
      check("rst_rd_valid", rd_valid, 1'b0);
      check("rst_rd_data", rd_data, 64'h0);
      check("rst_rd_last", rd_last, 1'b0);
      check("rst_done", done, 1'b0);
      check("rst_err", err, 1'b0);
      check("rst_mem_we", mem_we, 1'b0);
      check("rst_mem_addr", mem_addr, 20'h0);
      check("rst_mem_wd", mem_wd, 64'h0);
      RST_n = 1'b1;
      tick();

      // Single-beat load, stalled three-beat load, store with a wd gap.
      run_burst(1'b0, 20'h00010, 5'd1, 1'b1, 1'b0, -1, 0);
      run_burst(1'b0, 20'h00100, 5'd3, 1'b1, 1'b0, 1, 4);
      run_burst(1'b1, 20'h00200, 5'd2, 1'b1, 1'b0, 1, 3);
      for (int k = 0; k < 8; k++) begin
         check("t3_mem_beat0", tbmem[32'h200 + 8*k], 8'hA0 + 8'(k));
         check("t3_mem_beat1", tbmem[32'h201 + 8*k], 8'hB0 + 8'(k));
      end

      for (int i = 0; i < 10; i++)
         run_burst(tbl[i].st, tbl[i].addr, tbl[i].cnt, tbl[i].acc, 1'b1, -1, 0);

      // Reset while beat 1 of a four-beat store is being written.
      v0 = 64'h1122334455667788; v1 = 64'h99AABBCCDDEEFF00;
      req_valid = 1'b1; req_store = 1'b1; req_addr = 20'h00300; req_count = 5'd4;
      tick();
      req_valid = 1'b0;
      wd_valid = 1'b1; wd_data = v0;
      tick();
      wd_valid = 1'b0;
      tick();
      ref_write(32'h300, v0);
      wd_valid = 1'b1; wd_data = v1;
      tick();
      wd_valid = 1'b0;
      check("t5_we_before_reset", mem_we, 1'b1);
      #1 RST_n = 1'b0;
      #1;
      check("t5_we_async_clear", mem_we, 1'b0);
      check("t5_ready_in_reset", req_ready, 1'b1);
      tick();
      tick();
      RST_n = 1'b1;
      tick();
      check("t5_req_ready", req_ready, 1'b1);
      check("t5_rd_valid", rd_valid, 1'b0);
      check("t5_done", done, 1'b0);
      check("t5_mem_we", mem_we, 1'b0);
      check("t5_beat0", {tbmem[32'h300], tbmem[32'h338]}, {v0[7:0], v0[63:56]});
      check("t5_beat1", {tbmem[32'h301], tbmem[32'h339]}, {refmem[32'h301], refmem[32'h339]});
      check("t5_beat2", tbmem[32'h302], refmem[32'h302]);

      // req_valid held across a one-beat load followed by a one-beat store.
      we0 = we_cnt; hs0 = rd_hs; dn0 = done_cnt;
      req_valid = 1'b1; req_store = 1'b0; req_addr = 20'h00500; req_count = 5'd1; rd_ready = 1'b1;
      check("t6_ready0", req_ready, 1'b1);
      tick();
      check("t6_busy", req_ready, 1'b0);
      req_store = 1'b1; req_addr = 20'h00600;
      tick();
      check("t6_rd_valid", rd_valid, 1'b1);
      check("t6_rd_data", rd_data, ref_vec(32'h500));
      check("t6_rd_last", rd_last, 1'b1);
      tick();
      check("t6_ld_done", done, 1'b1);
      check("t6_ready_after_done", req_ready, 1'b1);
      tick();
      check("t6_store_accepted", req_ready, 1'b0);
      check("t6_wd_ready", wd_ready, 1'b1);
      check("t6_done_clear", done, 1'b0);
      req_valid = 1'b0; rd_ready = 1'b0;
      v0 = 64'hC0FFEE00DEADBEEF;
      wd_valid = 1'b1; wd_data = v0;
      tick();
      wd_valid = 1'b0;
      check("t6_we", mem_we, 1'b1);
      tick();
      ref_write(32'h600, v0);
      check("t6_st_done", done, 1'b1);
      tick();
      check("t6_idle", req_ready, 1'b1);
      check("t6_hs", rd_hs - hs0, 1);
      check("t6_we_cycles", we_cnt - we0, 1);
      check("t6_done_count", done_cnt - dn0, 2);

      for (int r = 0; r < 60; r++) begin
         int a, c, sel;
         logic st;
         st  = 1'($urandom_range(0, 1));
         sel = int'($urandom_range(0, 9));
         if (sel < 6)      a = int'($urandom_range(0, 36700));
         else if (sel < 9) a = int'($urandom_range(36760, 36863));
         else              a = int'($urandom_range(36864, 1048575));
         c = ($urandom_range(0, 15) == 0) ? 0 : int'($urandom_range(1, 16));
         run_burst(st, a[19:0], c[4:0], model_accept(a, c), 1'b1, -1, 0);
      end

      bad = 0;
      for (int i = 0; i < DEPTH; i++) if (tbmem[i] !== refmem[i]) bad++;
      check("mem_image", bad, 0);
      check("done_err_overlap", clash, 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
